// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table: NrRules base/length rules, one pipelined lookup per cycle.
// Optional lookup-miss counter is built only when CVA6_PMA_MISS_COUNTER_EN is defined.
module pma_region_table #(
  parameter int unsigned NrRules     = 4,
  parameter int unsigned AddrWidth   = 64,
  parameter int unsigned IdxWidth    = (NrRules > 1) ? $clog2(NrRules) : 1,
  parameter logic [2:0]  DefaultAttr = 3'b000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic [IdxWidth-1:0]  cfg_idx_i,
  input  logic [AddrWidth-1:0] cfg_base_i,
  input  logic [AddrWidth-1:0] cfg_len_i,
  input  logic [2:0]           cfg_attr_i,
  input  logic                 cfg_lock_i,
  output logic                 cfg_resp_valid_o,
  input  logic                 cfg_resp_ready_i,
  output logic                 cfg_resp_err_o,
  input  logic                 lkp_valid_i,
  input  logic [AddrWidth-1:0] lkp_addr_i,
  output logic                 lkp_valid_o,
  output logic                 lkp_hit_o,
  output logic [IdxWidth-1:0]  lkp_idx_o,
  output logic [2:0]           lkp_attr_o,
  output logic [31:0]          miss_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e                 state_r, state_s;
  logic                   ready_r, resp_valid_r, resp_err_r;
  logic [IdxWidth-1:0]    req_idx_r;
  logic [AddrWidth-1:0]   req_base_r, req_len_r;
  logic [2:0]             req_attr_r;
  logic                   req_lock_r;

  logic [AddrWidth-1:0]   base_r [NrRules];
  logic [AddrWidth-1:0]   len_r  [NrRules];
  logic [2:0]             attr_r [NrRules];
  logic [NrRules-1:0]     lock_r;

  logic                   idx_ok_s, idx_locked_s, commit_err_s;
  logic [NrRules-1:0]     match_s;
  logic                   hit_s;
  logic [IdxWidth-1:0]    hit_idx_s;
  logic [2:0]             hit_attr_s;

  logic                   lkp_valid_r, lkp_hit_r;
  logic [IdxWidth-1:0]    lkp_idx_r;
  logic [2:0]             lkp_attr_r;

  // Config FSM next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (cfg_valid_i && ready_r) state_s = COMMIT; else state_s = IDLE;
      COMMIT:  state_s = RESP;
      RESP:    if (cfg_resp_ready_i) state_s = IDLE; else state_s = RESP;
      default: state_s = IDLE;
    endcase
  end

  // Reject writes to out-of-range or locked rules
  always_comb begin
    idx_ok_s     = 1'b0;
    idx_locked_s = 1'b0;
    for (int i = 0; i < NrRules; i++) begin
      idx_ok_s     = idx_ok_s | (req_idx_r == IdxWidth'(i));
      idx_locked_s = idx_locked_s | ((req_idx_r == IdxWidth'(i)) & lock_r[i]);
    end
    commit_err_s = !idx_ok_s || idx_locked_s;
  end

  // FSM state, handshake outputs and request capture
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r      <= IDLE;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      req_idx_r    <= '0;
      req_base_r   <= '0;
      req_len_r    <= '0;
      req_attr_r   <= 3'b000;
      req_lock_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      ready_r      <= (state_s == IDLE);
      resp_valid_r <= (state_s == RESP);
      if (state_r == COMMIT) begin
        resp_err_r <= commit_err_s;
      end
      if (state_r == IDLE && cfg_valid_i && ready_r) begin
        req_idx_r  <= cfg_idx_i;
        req_base_r <= cfg_base_i;
        req_len_r  <= cfg_len_i;
        req_attr_r <= cfg_attr_i;
        req_lock_r <= cfg_lock_i;
      end
    end
  end

  // Rule storage; written only in COMMIT so same-cycle lookups see the old rule
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NrRules; i++) begin
        base_r[i] <= '0;
        len_r[i]  <= '0;
        attr_r[i] <= 3'b000;
        lock_r[i] <= 1'b0;
      end
    end else if (state_r == COMMIT && !commit_err_s) begin
      for (int i = 0; i < NrRules; i++) begin
        if (req_idx_r == IdxWidth'(i)) begin
          base_r[i] <= req_base_r;
          len_r[i]  <= req_len_r;
          attr_r[i] <= req_attr_r;
          lock_r[i] <= req_lock_r;
        end
      end
    end
  end

  // Region end uses one extra bit so a region touching the top of memory never wraps
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NrRules; i++) begin
      match_s[i] = (len_r[i] != '0) && (lkp_addr_i >= base_r[i]) &&
                   ({1'b0, lkp_addr_i} < ({1'b0, base_r[i]} + {1'b0, len_r[i]}));
    end
  end

  // Lowest matching index wins
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    hit_attr_s = DefaultAttr;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (match_s[i]) begin
        hit_s      = 1'b1;
        hit_idx_s  = IdxWidth'(i);
        hit_attr_s = attr_r[i];
      end else begin
        hit_s      = hit_s;
      end
    end
  end

  // Lookup result stage; results hold while no request is presented
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lkp_valid_r <= 1'b0;
      lkp_hit_r   <= 1'b0;
      lkp_idx_r   <= '0;
      lkp_attr_r  <= DefaultAttr;
    end else begin
      lkp_valid_r <= lkp_valid_i;
      if (lkp_valid_i) begin
        lkp_hit_r  <= hit_s;
        lkp_idx_r  <= hit_idx_s;
        lkp_attr_r <= hit_attr_s;
      end
    end
  end

`ifdef CVA6_PMA_MISS_COUNTER_EN
  logic [31:0] miss_cnt_r;

  // Saturating miss counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      miss_cnt_r <= 32'd0;
    end else if (lkp_valid_r && !lkp_hit_r && (miss_cnt_r != 32'hFFFF_FFFF)) begin
      miss_cnt_r <= miss_cnt_r + 32'd1;
    end
  end

  assign miss_cnt_o = miss_cnt_r;
`else
  assign miss_cnt_o = 32'd0;
`endif

  assign cfg_ready_o      = ready_r;
  assign cfg_resp_valid_o = resp_valid_r;
  assign cfg_resp_err_o   = resp_err_r;
  assign lkp_valid_o      = lkp_valid_r;
  assign lkp_hit_o        = lkp_hit_r;
  assign lkp_idx_o        = lkp_idx_r;
  assign lkp_attr_o       = lkp_attr_r;

endmodule

// File: tb/tb_pma_region_table.sv
// Self-checking bench for pma_region_table: directed scenarios plus randomized writes/lookups
// compared against a first-match region model.
module tb_pma_region_table;

  localparam int         NR  = 5;
  localparam logic [2:0] DEF = 3'b010;

  logic        clk;
  logic        rst_i;
  logic        cfg_valid_i, cfg_ready_o;
  logic [2:0]  cfg_idx_i;
  logic [63:0] cfg_base_i, cfg_len_i;
  logic [2:0]  cfg_attr_i;
  logic        cfg_lock_i;
  logic        cfg_resp_valid_o, cfg_resp_ready_i, cfg_resp_err_o;
  logic        lkp_valid_i;
  logic [63:0] lkp_addr_i;
  logic        lkp_valid_o, lkp_hit_o;
  logic [2:0]  lkp_idx_o;
  logic [2:0]  lkp_attr_o;
  logic [31:0] miss_cnt_o;

  pma_region_table #(.NrRules(NR), .AddrWidth(64), .DefaultAttr(DEF)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_idx_i(cfg_idx_i),
    .cfg_base_i(cfg_base_i), .cfg_len_i(cfg_len_i), .cfg_attr_i(cfg_attr_i),
    .cfg_lock_i(cfg_lock_i), .cfg_resp_valid_o(cfg_resp_valid_o),
    .cfg_resp_ready_i(cfg_resp_ready_i), .cfg_resp_err_o(cfg_resp_err_o),
    .lkp_valid_i(lkp_valid_i), .lkp_addr_i(lkp_addr_i), .lkp_valid_o(lkp_valid_o),
    .lkp_hit_o(lkp_hit_o), .lkp_idx_o(lkp_idx_o), .lkp_attr_o(lkp_attr_o),
    .miss_cnt_o(miss_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // reference model of the table
  logic [63:0] m_base [NR];
  logic [63:0] m_len  [NR];
  logic [2:0]  m_attr [NR];
  logic        m_lock [NR];
  logic        e_hit;
  logic [2:0]  e_idx, e_attr;
  int          misses;
  logic        last_err;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int r = 0; r < NR; r++) begin
      m_base[r] = 64'd0; m_len[r] = 64'd0; m_attr[r] = 3'b000; m_lock[r] = 1'b0;
    end
    e_hit = 1'b0; e_idx = 3'd0; e_attr = DEF; misses = 0;
  endtask

  // first enabled rule whose byte range [base, base+len) contains a
  function automatic void model(input logic [63:0] a, output logic h,
                                output logic [2:0] i, output logic [2:0] at);
    h = 1'b0; i = 3'd0; at = DEF;
    for (int r = 0; r < NR; r++) begin
      if (!h && m_len[r] != 64'd0 && a >= m_base[r] && (a - m_base[r]) < m_len[r]) begin
        h = 1'b1; i = 3'(r); at = m_attr[r];
      end
    end
  endfunction

  task automatic lkp(input logic v, input logic [63:0] a);
    logic h;
    logic [2:0] i, at;
    lkp_valid_i = v;
    lkp_addr_i  = a;
    if (v) begin
      model(a, h, i, at);
      e_hit = h; e_idx = i; e_attr = at;
      if (!h) misses++;
    end
    step();
    lkp_valid_i = 1'b0;
    chk("lkp_valid", lkp_valid_o, v);
    chk("lkp_hit", lkp_hit_o, e_hit);
    chk("lkp_idx", lkp_idx_o, e_idx);
    chk("lkp_attr", lkp_attr_o, e_attr);
  endtask

  // accept a write, probe lookups in COMMIT (old table) and RESP (new table); leaves FSM in RESP
  task automatic cfg_issue(input logic [2:0] idx, input logic [63:0] base, input logic [63:0] len,
                           input logic [2:0] attr, input logic lock, input logic [63:0] probe);
    int w;
    cfg_valid_i = 1'b1; cfg_idx_i = idx; cfg_base_i = base; cfg_len_i = len;
    cfg_attr_i = attr; cfg_lock_i = lock;
    w = 0;
    while (cfg_ready_o !== 1'b1 && w < 20) begin
      step();
      w++;
    end
    chk("cfg_ready_idle", cfg_ready_o, 1'b1);
    step();
    cfg_valid_i = 1'b0;
    chk("resp_not_yet", cfg_resp_valid_o, 1'b0);
    chk("ready_busy", cfg_ready_o, 1'b0);
    last_err = (idx >= 3'(NR)) ? 1'b1 : m_lock[idx];
    lkp(1'b1, probe);
    if (!last_err) begin
      m_base[idx] = base; m_len[idx] = len; m_attr[idx] = attr; m_lock[idx] = lock;
    end
    chk("resp_latency", cfg_resp_valid_o, 1'b1);
    chk("resp_err", cfg_resp_err_o, last_err);
    lkp(1'b1, probe);
    chk("resp_hold", cfg_resp_valid_o, 1'b1);
    chk("ready_resp", cfg_ready_o, 1'b0);
  endtask

  task automatic cfg_finish();
    cfg_resp_ready_i = 1'b1;
    step();
    cfg_resp_ready_i = 1'b0;
    chk("resp_done", cfg_resp_valid_o, 1'b0);
    chk("ready_back", cfg_ready_o, 1'b1);
  endtask

  task automatic miss_chk();
    step();
    step();
`ifdef CVA6_PMA_MISS_COUNTER_EN
    chk("miss_cnt", miss_cnt_o, 64'(misses));
`else
    chk("miss_cnt", miss_cnt_o, 64'd0);
`endif
  endtask

  function automatic logic [63:0] rand_addr();
    int r;
    r = $urandom_range(0, NR - 1);
    case ($urandom_range(0, 3))
      0:       return {$urandom, $urandom};
      1:       return m_base[r] + m_len[r] + 64'($urandom_range(0, 2)) - 64'd2;
      default: return m_base[r] + 64'($urandom_range(0, 64)) - 64'd32;
    endcase
  endfunction

  initial begin
    logic [2:0]  ridx;
    logic [63:0] rbase, rlen;
    rst_i = 1'b1; cfg_valid_i = 1'b0; cfg_idx_i = 3'd0; cfg_base_i = 64'd0; cfg_len_i = 64'd0;
    cfg_attr_i = 3'b000; cfg_lock_i = 1'b0; cfg_resp_ready_i = 1'b0;
    lkp_valid_i = 1'b0; lkp_addr_i = 64'd0; last_err = 1'b0;
    reset_model();
    step();
    step();
    rst_i = 1'b0;
    chk("rst_ready", cfg_ready_o, 1'b1);
    chk("rst_resp_valid", cfg_resp_valid_o, 1'b0);
    chk("rst_resp_err", cfg_resp_err_o, 1'b0);
    chk("rst_lkp_valid", lkp_valid_o, 1'b0);
    chk("rst_hit", lkp_hit_o, 1'b0);
    chk("rst_idx", lkp_idx_o, 3'd0);
    chk("rst_attr", lkp_attr_o, DEF);
    chk("rst_miss", miss_cnt_o, 32'd0);

    // single large region
    cfg_issue(3'd0, 64'h8000_0000, 64'h4000_0000, 3'b110, 1'b0, 64'h8000_0000);
    cfg_finish();
    lkp(1'b1, 64'h8000_0000);
    chk("t1_base_hit", {lkp_hit_o, lkp_idx_o, lkp_attr_o}, {1'b1, 3'd0, 3'b110});
    lkp(1'b1, 64'hBFFF_FFFF);
    chk("t1_last_hit", lkp_hit_o, 1'b1);
    lkp(1'b1, 64'hC000_0000);
    chk("t1_end_miss", {lkp_hit_o, lkp_idx_o, lkp_attr_o}, {1'b0, 3'd0, DEF});
    lkp(1'b0, 64'h8000_0000);
    chk("t1_hold_attr", lkp_attr_o, DEF);

    // overlapping rules, lowest index wins
    cfg_issue(3'd0, 64'h1000, 64'h1000, 3'b001, 1'b0, 64'h1800);
    cfg_finish();
    cfg_issue(3'd1, 64'h0, 64'h1_0000, 3'b100, 1'b0, 64'h2800);
    cfg_finish();
    lkp(1'b1, 64'h1800);
    chk("t2_overlap", {lkp_idx_o, lkp_attr_o}, {3'd0, 3'b001});
    lkp(1'b1, 64'h2800);
    chk("t2_outer", {lkp_idx_o, lkp_attr_o}, {3'd1, 3'b100});

    // locking and out-of-range index
    cfg_issue(3'd2, 64'h2_0000, 64'h1000, 3'b011, 1'b1, 64'h2_0010);
    cfg_finish();
    cfg_issue(3'd2, 64'h2_0000, 64'h0, 3'b000, 1'b0, 64'h2_0010);
    chk("t3_locked_err", cfg_resp_err_o, 1'b1);
    cfg_finish();
    lkp(1'b1, 64'h2_0010);
    chk("t3_still_hit", {lkp_hit_o, lkp_idx_o, lkp_attr_o}, {1'b1, 3'd2, 3'b011});
    cfg_issue(3'(NR), 64'h5_0000, 64'h100, 3'b111, 1'b0, 64'h5_0000);
    chk("t3_idx_err", cfg_resp_err_o, 1'b1);
    cfg_finish();

    // region ending at the top of the address space
    cfg_issue(3'd3, 64'hFFFF_FFFF_FFFF_FF00, 64'h100, 3'b101, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    cfg_finish();
    lkp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_top_hit", {lkp_hit_o, lkp_idx_o}, {1'b1, 3'd3});
    lkp(1'b1, 64'hFFFF_FFFF_FFFF_FEFF);
    chk("t4_below_miss", lkp_hit_o, 1'b0);
    miss_chk();

    // randomized writes and lookup bursts
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        ridx = 3'($urandom_range(0, 6));
        case ($urandom_range(0, 3))
          0: begin
            rlen  = 64'($urandom_range(1, 16'h800));
            rbase = 64'd0 - rlen;
          end
          1: begin
            rlen  = 64'd0;
            rbase = 64'($urandom_range(0, 32'h2_FFFF));
          end
          default: begin
            rlen  = 64'($urandom_range(1, 16'h8000));
            rbase = 64'($urandom_range(0, 32'h2_FFFF));
          end
        endcase
        cfg_issue(ridx, rbase, rlen, 3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                  rand_addr());
        cfg_finish();
      end else begin
        for (int k = 0; k < 6; k++) begin
          lkp(($urandom_range(0, 3) != 0), rand_addr());
        end
      end
    end
    miss_chk();

    // response backpressure, then reset while in RESP
    cfg_issue(3'd4, 64'h4_0000, 64'h100, 3'b111, 1'b0, 64'h4_0000);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t5_resp_stable", cfg_resp_valid_o, 1'b1);
      chk("t5_err_stable", cfg_resp_err_o, last_err);
      chk("t5_ready_low", cfg_ready_o, 1'b0);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    reset_model();
    chk("t5_rst_resp", cfg_resp_valid_o, 1'b0);
    chk("t5_rst_ready", cfg_ready_o, 1'b1);
    chk("t5_rst_lkp_valid", lkp_valid_o, 1'b0);
    chk("t5_rst_attr", lkp_attr_o, DEF);
    chk("t5_rst_miss", miss_cnt_o, 32'd0);
    lkp(1'b1, 64'h8000_0000);
    lkp(1'b1, 64'h2_0010);
    chk("t5_cleared", lkp_hit_o, 1'b0);
    lkp(1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    cfg_issue(3'd2, 64'h3_0000, 64'h100, 3'b001, 1'b0, 64'h3_0080);
    chk("t5_unlocked", cfg_resp_err_o, 1'b0);
    cfg_finish();

    // miss counting: three misses, two hits
    lkp(1'b1, 64'h9_0000);
    lkp(1'b1, 64'h3_0000);
    lkp(1'b1, 64'h3_0100);
    lkp(1'b1, 64'h3_00FF);
    lkp(1'b1, 64'h0);
    miss_chk();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
